// File: rtl/spi_reg_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge_pkg
// Shared definitions for the SPI-to-register bridge:
//   - ADDR_W  : register address / pointer width (7 bits)
//   - RW_BIT  : bit position of the read/write flag in the command byte
//   - BYTE_W  : SPI byte width
//   - state_t : bridge FSM state encoding
//   - cmd_addr(): extracts the start address from a command byte
// -----------------------------------------------------------------------------
package spi_reg_bridge_pkg;

    localparam int ADDR_W = 7;
    localparam int RW_BIT = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [BYTE_W-1:0] cmd_byte);
        return cmd_byte[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/spi_reg_bridge_edge_det.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge_edge_det
// Falling-edge detector for an already-synchronous level signal.
//   Clock  : system clock (rising edge)
//   Reset  : asynchronous, active-low reset
//   level  : monitored signal
//   fall   : combinational pulse, high in the cycle where level is 0 and
//            was 1 at the previous clock edge
// RESET_LEVEL sets the assumed previous level after reset. Resetting it to 0
// means a signal that is already low when reset releases is not reported
// as a falling edge.
// -----------------------------------------------------------------------------
module spi_reg_bridge_edge_det #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic level,
    output logic fall
);

    logic level_reg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            level_reg <= RESET_LEVEL;
        end else begin
            level_reg <= level;
        end
    end

    assign fall = level_reg & ~level;

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Turns a byte stream from an SPI slave into register-bus accesses.
// First byte of a transaction is a command: bit 7 = 1 read, 0 write,
// bits 6:0 = start address. Following bytes are write data (write) or
// dummy bytes that clock out prefetched read data (read).
//
// Ports:
//   Clock, Reset          : system clock, asynchronous active-low reset
//   CsN_i                 : chip select (active low, synchronous to Clock)
//   ByteValid_i, Byte_i   : received-byte strobe and data
//   TxByte_o              : next byte for the SPI slave to shift out
//   RegAddr_o             : register address
//   RegWrData_o, RegWrEn_o: write data and one-cycle write strobe
//   RegRdEn_o, RegRdData_i: one-cycle read strobe, data valid the cycle after
//   Busy_o                : FSM not idle
//   Overrun_o             : sticky, a byte was dropped in this transaction
//
// Build option: define SPI_REG_BRIDGE_AUTOINC_EN to advance the address
// pointer after every access; otherwise the pointer holds the command
// address for the whole transaction.
// -----------------------------------------------------------------------------
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CsN_i,
    input  logic              ByteValid_i,
    input  logic [BYTE_W-1:0] Byte_i,
    output logic [BYTE_W-1:0] TxByte_o,
    output logic [ADDR_W-1:0] RegAddr_o,
    output logic [BYTE_W-1:0] RegWrData_o,
    output logic              RegWrEn_o,
    output logic              RegRdEn_o,
    input  logic [BYTE_W-1:0] RegRdData_i,
    output logic              Busy_o,
    output logic              Overrun_o
);

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [BYTE_W-1:0] tx_byte_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [BYTE_W-1:0] wr_data_reg;
    logic              wr_en_reg;
    logic              rd_en_reg;
    logic              overrun_reg;
    logic              cs_fall;

    // Previous level resets low so that a chip select already asserted at
    // reset release is not taken as a new transaction start.
    spi_reg_bridge_edge_det #(
        .RESET_LEVEL (1'b0)
    ) u_cs_edge (
        .Clock (Clock),
        .Reset (Reset),
        .level (CsN_i),
        .fall  (cs_fall)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            tx_byte_reg <= IDLE_BYTE;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wr_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;

            if (CsN_i) begin
                // Deselect wins over everything, including a byte strobe
                // arriving in the same cycle.
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg   <= ST_CMD;
                            tx_byte_reg <= IDLE_BYTE;
                            overrun_reg <= 1'b0;
                        end
                    end

                    ST_CMD: begin
                        if (ByteValid_i) begin
                            ptr_reg <= cmd_addr(Byte_i);
                            if (Byte_i[RW_BIT]) begin
                                // Issue the first read on entry to RD_WAIT.
                                state_reg <= ST_RD_WAIT;
                                rd_en_reg <= 1'b1;
                                addr_reg  <= cmd_addr(Byte_i);
                            end else begin
                                state_reg <= ST_WR_DATA;
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (ByteValid_i) begin
                            wr_en_reg   <= 1'b1;
                            addr_reg    <= ptr_reg;
                            wr_data_reg <= Byte_i;
                            ptr_reg     <= ptr_reg + PTR_STEP;
                        end
                    end

                    ST_RD_WAIT: begin
                        // The slave cannot have loaded the previous byte yet;
                        // anything arriving here is lost.
                        if (ByteValid_i) begin
                            overrun_reg <= 1'b1;
                        end
                        // First RD_WAIT cycle carries the strobe; read data
                        // is valid in the second one.
                        if (!rd_en_reg) begin
                            tx_byte_reg <= RegRdData_i;
                            ptr_reg     <= ptr_reg + PTR_STEP;
                            state_reg   <= ST_RD_DATA;
                        end
                    end

                    ST_RD_DATA: begin
                        // The received byte is a dummy; it only signals that
                        // TxByte_o has been shifted out, so prefetch the next.
                        if (ByteValid_i) begin
                            state_reg <= ST_RD_WAIT;
                            rd_en_reg <= 1'b1;
                            addr_reg  <= ptr_reg;
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign TxByte_o    = tx_byte_reg;
    assign RegAddr_o   = addr_reg;
    assign RegWrData_o = wr_data_reg;
    assign RegWrEn_o   = wr_en_reg;
    assign RegRdEn_o   = rd_en_reg;
    assign Busy_o      = (state_reg != ST_IDLE);
    assign Overrun_o   = overrun_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Self-checking bench for spi_reg_bridge. A register-bus monitor logs every
// strobe as an access record; each transaction's expected access list and
// expected TxByte sequence are computed from the protocol rules (start
// address, optional +1 step per access, 7-bit wrap) and compared after the
// transaction. Read data is defined as ((addr + 0x40) ^ rd_salt).
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    logic       Clock       = 1'b0;
    logic       Reset       = 1'b0;
    logic       CsN_i       = 1'b1;
    logic       ByteValid_i = 1'b0;
    logic [7:0] Byte_i      = 8'h00;
    logic [7:0] TxByte_o;
    logic [6:0] RegAddr_o;
    logic [7:0] RegWrData_o;
    logic       RegWrEn_o;
    logic       RegRdEn_o;
    logic [7:0] RegRdData_i = 8'h00;
    logic       Busy_o;
    logic       Overrun_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rd_salt  = 8'h00;
    int         obs_q[$];
    int         exp_q[$];
    logic [7:0] wr_bytes[$];

    spi_reg_bridge #(
        .IDLE_BYTE (IDLE_BYTE)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .CsN_i       (CsN_i),
        .ByteValid_i (ByteValid_i),
        .Byte_i      (Byte_i),
        .TxByte_o    (TxByte_o),
        .RegAddr_o   (RegAddr_o),
        .RegWrData_o (RegWrData_o),
        .RegWrEn_o   (RegWrEn_o),
        .RegRdEn_o   (RegRdEn_o),
        .RegRdData_i (RegRdData_i),
        .Busy_o      (Busy_o),
        .Overrun_o   (Overrun_o)
    );

    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int enc(input int wr, input int addr, input int data);
        return ((wr & 1) << 15) | ((addr & 127) << 8) | (data & 255);
    endfunction

    function automatic logic [7:0] rd_val(input int addr);
        return 8'(((addr & 127) + 'h40) & 255) ^ rd_salt;
    endfunction

    // Register-bus model: read data appears the cycle after the strobe.
    always @(posedge Clock) begin
        if (RegRdEn_o) RegRdData_i <= rd_val(int'(RegAddr_o));
    end

    // Access monitor, sampled on the falling edge.
    always @(negedge Clock) begin
        if (RegWrEn_o || RegRdEn_o) begin
            check_value("strobe_excl", 32'(RegWrEn_o & RegRdEn_o), 32'd0);
            if (RegWrEn_o) obs_q.push_back(enc(1, int'(RegAddr_o), int'(RegWrData_o)));
            else           obs_q.push_back(enc(0, int'(RegAddr_o), 0));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ByteValid_i = 1'b1;
        Byte_i      = b;
        tick(1);
        ByteValid_i = 1'b0;
        Byte_i      = 8'($urandom);
        tick(int'($urandom_range(4, 7)));
    endtask

    task automatic compare_accesses(input string tag);
        int n;
        check_value({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_value({tag, "_access"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    // One complete transaction: command, then n data bytes (write, taken from
    // wr_bytes) or n dummy bytes (read).
    task automatic run_txn(input string tag, input bit is_rd, input logic [6:0] addr, input int n);
        int         ptr;
        logic [7:0] exp_tx[$];
        obs_q.delete();
        exp_q.delete();
        ptr = int'(addr);
        if (is_rd) begin
            for (int i = 0; i <= n; i++) begin
                exp_q.push_back(enc(0, ptr, 0));
                exp_tx.push_back(rd_val(ptr));
                ptr = (ptr + STEP) % 128;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(enc(1, ptr, int'(wr_bytes[i])));
                ptr = (ptr + STEP) % 128;
            end
        end

        CsN_i = 1'b0;
        tick(int'($urandom_range(1, 3)));
        check_value({tag, "_busy"}, 32'(Busy_o), 32'd1);
        check_value({tag, "_tx_start"}, 32'(TxByte_o), 32'(IDLE_BYTE));
        send_byte({is_rd, addr});
        if (is_rd) begin
            check_value({tag, "_tx"}, 32'(TxByte_o), 32'(exp_tx[0]));
            for (int i = 1; i <= n; i++) begin
                send_byte(8'($urandom));
                check_value({tag, "_tx"}, 32'(TxByte_o), 32'(exp_tx[i]));
            end
        end else begin
            for (int i = 0; i < n; i++) send_byte(wr_bytes[i]);
            check_value({tag, "_tx_idle"}, 32'(TxByte_o), 32'(IDLE_BYTE));
        end
        check_value({tag, "_overrun"}, 32'(Overrun_o), 32'd0);
        CsN_i = 1'b1;
        tick(2);
        check_value({tag, "_busy_end"}, 32'(Busy_o), 32'd0);
        compare_accesses(tag);
        $display("txn %s: %s addr=%02h bytes=%0d accesses=%0d", tag, is_rd ? "read" : "write",
                 addr, n, obs_q.size());
    endtask

    initial begin
        // Reset state
        tick(3);
        check_value("rst_tx", 32'(TxByte_o), 32'(IDLE_BYTE));
        check_value("rst_addr", 32'(RegAddr_o), 32'd0);
        check_value("rst_wrdata", 32'(RegWrData_o), 32'd0);
        check_value("rst_wren", 32'(RegWrEn_o), 32'd0);
        check_value("rst_rden", 32'(RegRdEn_o), 32'd0);
        check_value("rst_busy", 32'(Busy_o), 32'd0);
        check_value("rst_overrun", 32'(Overrun_o), 32'd0);
        Reset = 1'b1;
        tick(2);
        $display("txn reset: state checked");

        // Directed write 05, A1, B2
        wr_bytes = '{8'hA1, 8'hB2};
        run_txn("write", 1'b0, 7'h05, 2);

        // Directed read 0x90 plus one dummy byte
        rd_salt = 8'h00;
        run_txn("read", 1'b1, 7'h10, 1);

        // Address wrap
        wr_bytes = '{8'h3C, 8'hC3};
        run_txn("wrap", 1'b0, 7'h7F, 2);
        rd_salt = 8'h5A;
        run_txn("rdwrap", 1'b1, 7'h7F, 2);

        // Abort: deselect after the command byte, byte strobes while deselected
        obs_q.delete();
        exp_q.delete();
        CsN_i = 1'b0;
        tick(1);
        send_byte(8'h05);
        CsN_i       = 1'b1;
        ByteValid_i = 1'b1;
        Byte_i      = 8'hA1;
        tick(1);
        ByteValid_i = 1'b0;
        check_value("abort_busy", 32'(Busy_o), 32'd0);
        tick(2);
        ByteValid_i = 1'b1;
        Byte_i      = 8'hB2;
        tick(1);
        ByteValid_i = 1'b0;
        tick(3);
        compare_accesses("abort");
        CsN_i = 1'b0;
        tick(1);
        check_value("abort_restart_busy", 32'(Busy_o), 32'd1);
        exp_q.push_back(enc(1, 3, 'h5A));
        send_byte(8'h03);
        send_byte(8'h5A);
        CsN_i = 1'b1;
        tick(2);
        compare_accesses("abort_restart");
        $display("txn abort: accesses=%0d", obs_q.size());

        // Overrun: byte arrives during RD_WAIT
        obs_q.delete();
        exp_q.delete();
        rd_salt = 8'h00;
        exp_q.push_back(enc(0, 'h22, 0));
        CsN_i = 1'b0;
        tick(1);
        ByteValid_i = 1'b1;
        Byte_i      = 8'hA2;
        tick(1);
        Byte_i      = 8'h33;
        tick(1);
        ByteValid_i = 1'b0;
        tick(4);
        check_value("ovr_set", 32'(Overrun_o), 32'd1);
        check_value("ovr_tx", 32'(TxByte_o), 32'(rd_val('h22)));
        CsN_i = 1'b1;
        tick(2);
        check_value("ovr_sticky", 32'(Overrun_o), 32'd1);
        compare_accesses("ovr");
        CsN_i = 1'b0;
        tick(1);
        check_value("ovr_clear", 32'(Overrun_o), 32'd0);
        CsN_i = 1'b1;
        tick(2);
        $display("txn overrun: accesses=%0d", obs_q.size());

        // Reset mid-transaction with chip select held low
        obs_q.delete();
        exp_q.delete();
        CsN_i = 1'b0;
        tick(1);
        send_byte(8'h20);
        send_byte(8'h77);
        check_value("mid_pre_access", 32'(obs_q.size()), 32'd1);
        Reset = 1'b0;
        #1;
        check_value("mid_rst_busy", 32'(Busy_o), 32'd0);
        check_value("mid_rst_addr", 32'(RegAddr_o), 32'd0);
        obs_q.delete();
        tick(2);
        Reset = 1'b1;
        tick(1);
        send_byte(8'h11);
        send_byte(8'h22);
        check_value("mid_wait_busy", 32'(Busy_o), 32'd0);
        compare_accesses("mid_rst");
        CsN_i = 1'b1;
        tick(2);
        $display("txn reset_mid: accesses=%0d", obs_q.size());

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            bit         is_rd;
            logic [6:0] addr;
            int         n;
            is_rd   = 1'($urandom);
            addr    = ($urandom_range(0, 3) == 0) ? 7'(7'h7C + $urandom_range(0, 3)) : 7'($urandom);
            n       = int'($urandom_range(0, 4));
            rd_salt = 8'($urandom);
            wr_bytes.delete();
            for (int i = 0; i < n; i++) wr_bytes.push_back(8'($urandom));
            run_txn("rand", is_rd, addr, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
